// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: default widths, FSM state
// constants and request op encoding.
// Ports: none (package only).
package mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 8;

  // FSM state encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WAIT     = 3'd1;
  localparam state_t ST_RESP     = 3'd2;
  localparam state_t ST_DUMP     = 3'd3;
  localparam state_t ST_DUMP_END = 3'd4;

  // Op is latched as {write, read}; both bits set marks a conflicting request.
  typedef logic [1:0] op_t;
  localparam op_t OP_RD = 2'b01;
  localparam op_t OP_WR = 2'b10;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, read-first, no reset of contents.
// Latency: rdata is the word at addr one clock after addr is presented.
// Backpressure: none; the port is accepted every cycle.
// Ports: clk, we (write enable), addr (word index), wdata, rdata (registered).
module mem_array import mem_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one read/write at a time with wait states, plus full-array dump.
// Latency: ack RD_LAT+1 / WR_LAT+1 cycles after acceptance; dump streams one word/cycle after one fill cycle.
// Backpressure: initiator holds read/write until ack; requests are not accepted while busy or dumping.
// Ports: clk, reset (async active-low), read/write/addr/din request side,
//        dout/ack/err/busy response side, dump_en/dump_data/dump_valid/dump_done dump side.
module mem_responder import mem_pkg::*; #(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = 65536,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              ack,
  output logic              err,
  output logic              busy,
  input  logic              dump_en,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_valid,
  output logic              dump_done
);

  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  // Counter holds LAT-1 down to 0.
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  op_t               op_q;
  logic [IDX_W-1:0]  idx_q;
  logic              oor_q;
  logic [DATA_W-1:0] din_q;
  logic [ADDR_W:0]   dcnt;
  logic [DATA_W-1:0] dout_q;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              rd_ok;

  // The dump and the request path share the single RAM port; the FSM state picks the owner.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = idx_q;
    if (state == ST_DUMP) begin
      ram_addr = dcnt[IDX_W-1:0];
    end else if (state == ST_WAIT && cnt == '0 && op_q == OP_WR && !oor_q) begin
      ram_we = 1'b1;
    end
  end

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (din_q),
    .rdata (ram_rdata)
  );

  // A plain read (in or out of range) updates dout; conflicting requests leave it alone.
  assign rd_ok      = (state == ST_RESP) && (op_q == OP_RD);
  assign ack        = (state == ST_RESP);
  assign err        = ack && (oor_q || op_q == (OP_RD | OP_WR));
  assign busy       = (state == ST_WAIT) || (state == ST_RESP) || (state == ST_DUMP);
  // dcnt==0 is the fill cycle: RAM output not yet valid.
  assign dump_valid = (state == ST_DUMP) && (dcnt != '0);
  assign dump_data  = dump_valid ? ram_rdata : '0;
  assign dump_done  = (state == ST_DUMP_END);
  // RAM data is only available in the RESP cycle itself, so bypass the holding register there.
  assign dout       = !rd_ok ? dout_q : (oor_q ? '0 : ram_rdata);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      idx_q  <= '0;
      oor_q  <= 1'b0;
      din_q  <= '0;
      dcnt   <= '0;
      dout_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dump_en) begin
            state <= ST_DUMP;
            dcnt  <= '0;
          end else if (read || write) begin
            state <= ST_WAIT;
            op_q  <= {write, read};
            idx_q <= addr[IDX_W-1:0];
            oor_q <= ({1'b0, addr} >= DEPTH_X);
            din_q <= din;
            cnt   <= (write && !read) ? CNT_W'(WR_LAT-1) : CNT_W'(RD_LAT-1);
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (rd_ok) begin
            dout_q <= dout;
          end
        end
        ST_DUMP: begin
          // Counter is one bit wider than the address so DEPTH=2^ADDR_W ends cleanly.
          if (dcnt == DEPTH_X) begin
            state <= ST_DUMP_END;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        ST_DUMP_END: state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a full-depth instance (index 0) and a DEPTH=16 instance (index 1).
// Each instance has its own request/dump inputs; a behavioural model predicts ack latency, err and dout.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0]      rd, wr, den;
  logic [1:0][15:0] addr;
  logic [1:0][7:0]  din;
  wire  [1:0][7:0]  dout, ddat;
  wire  [1:0]       ack, err, busy, dvld, ddone;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state.
  logic [7:0] big_mem [int];
  logic [7:0] small_mem [16];
  logic [7:0] mdl_dout [2];

  mem_responder #(.ADDR_W(16), .DATA_W(8), .DEPTH(65536), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) u_big (
    .clk(clk), .reset(rst_n), .read(rd[0]), .write(wr[0]), .addr(addr[0]), .din(din[0]),
    .dout(dout[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]), .dump_en(den[0]),
    .dump_data(ddat[0]), .dump_valid(dvld[0]), .dump_done(ddone[0]));

  mem_responder #(.ADDR_W(16), .DATA_W(8), .DEPTH(16), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) u_small (
    .clk(clk), .reset(rst_n), .read(rd[1]), .write(wr[1]), .addr(addr[1]), .din(din[1]),
    .dout(dout[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]), .dump_en(den[1]),
    .dump_data(ddat[1]), .dump_valid(dvld[1]), .dump_done(ddone[1]));

  // Predict a single request's outcome from the protocol rules and update the model memory.
  task automatic model(input int i, input bit r, input bit w, input logic [15:0] a, input logic [7:0] d,
                       output int lat, output logic e, output logic [7:0] q);
    int dep;
    bit oor;
    dep = (i == 0) ? 65536 : 16;
    oor = (int'(a) >= dep);
    e   = (r && w) || oor;
    lat = (r && !w) ? RD_LAT + 1 : ((w && !r) ? WR_LAT + 1 : -1);
    if (r && !w) mdl_dout[i] = oor ? 8'h00 : ((i == 0) ? big_mem[int'(a)] : small_mem[a[3:0]]);
    if (w && !r && !oor) begin
      if (i == 0) big_mem[int'(a)] = d;
      else        small_mem[a[3:0]] = d;
    end
    q = mdl_dout[i];
  endtask

  // Drive one request from an idle DUT, wait (bounded) for ack, drop it, leave one idle cycle.
  task automatic do_req(input int i, input bit r, input bit w, input logic [15:0] a, input logic [7:0] d,
                        output int lat, output logic e, output logic [7:0] q);
    rd[i] = r; wr[i] = w; addr[i] = a; din[i] = d;
    lat = -1; e = 1'b0; q = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack[i]) begin
        lat = c; e = err[i]; q = dout[i];
        break;
      end
    end
    rd[i] = 1'b0; wr[i] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rd = '0; wr = '0; den = '0; addr = '0; din = '0;
    mdl_dout[0] = 8'h00; mdl_dout[1] = 8'h00;
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ack, err, busy, dvld, ddone} !== 10'b0) $display("FAIL reset_ctrl got %b want 0", {ack, err, busy, dvld, ddone});
    else n_pass++;
    n_chk++;
    if ({dout, ddat} !== 32'b0) $display("FAIL reset_data got %h want 0", {dout, ddat});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int el, lat; logic ee, e; logic [7:0] eq, q;
    model(0, 0, 1, 16'h0010, 8'hA5, el, ee, eq);
    do_req(0, 0, 1, 16'h0010, 8'hA5, lat, e, q);
    n_chk++; if (lat !== el) $display("FAIL wr_latency got %0d want %0d", lat, el); else n_pass++;
    n_chk++; if (e !== ee) $display("FAIL wr_err got %b want %b", e, ee); else n_pass++;
    model(0, 1, 0, 16'h0010, 8'h00, el, ee, eq);
    do_req(0, 1, 0, 16'h0010, 8'h00, lat, e, q);
    n_chk++; if (lat !== el) $display("FAIL rd_latency got %0d want %0d", lat, el); else n_pass++;
    n_chk++; if (q !== eq) $display("FAIL rd_data got %h want %h", q, eq); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int el, lat, c1, c2; logic ee, e; logic [7:0] eq, q;
    model(0, 0, 1, 16'h0001, 8'h11, el, ee, eq);
    model(0, 0, 1, 16'h0002, 8'h22, el, ee, eq);
    wr[0] = 1'b1; addr[0] = 16'h0001; din[0] = 8'h11;
    c1 = -1; c2 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack[0] && c1 < 0) begin
        c1 = c; addr[0] = 16'h0002; din[0] = 8'h22;
      end else if (ack[0]) begin
        c2 = c; wr[0] = 1'b0;
        break;
      end
    end
    wr[0] = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (c1 < 0 || c2 - c1 !== WR_LAT + 2) $display("FAIL b2b_gap got %0d want %0d", c2 - c1, WR_LAT + 2);
    else n_pass++;
    model(0, 1, 0, 16'h0001, 8'h00, el, ee, eq);
    do_req(0, 1, 0, 16'h0001, 8'h00, lat, e, q);
    n_chk++; if (q !== eq) $display("FAIL b2b_rd1 got %h want %h", q, eq); else n_pass++;
    model(0, 1, 0, 16'h0002, 8'h00, el, ee, eq);
    do_req(0, 1, 0, 16'h0002, 8'h00, lat, e, q);
    n_chk++; if (q !== eq) $display("FAIL b2b_rd2 got %h want %h", q, eq); else n_pass++;
  endtask

  task automatic test_conflict();
    int el, lat; logic ee, e; logic [7:0] eq, q;
    model(0, 0, 1, 16'h0005, 8'h5C, el, ee, eq);
    do_req(0, 0, 1, 16'h0005, 8'h5C, lat, e, q);
    model(0, 1, 1, 16'h0005, 8'hFF, el, ee, eq);
    do_req(0, 1, 1, 16'h0005, 8'hFF, lat, e, q);
    n_chk++; if (lat < 0) $display("FAIL conflict_ack got timeout want ack"); else n_pass++;
    n_chk++; if (e !== ee) $display("FAIL conflict_err got %b want %b", e, ee); else n_pass++;
    n_chk++; if (q !== eq) $display("FAIL conflict_dout got %h want %h", q, eq); else n_pass++;
    model(0, 1, 0, 16'h0005, 8'h00, el, ee, eq);
    do_req(0, 1, 0, 16'h0005, 8'h00, lat, e, q);
    n_chk++; if (q !== eq) $display("FAIL conflict_keep got %h want %h", q, eq); else n_pass++;
  endtask

  task automatic test_out_of_range();
    int el, lat; logic ee, e; logic [7:0] eq, q;
    model(1, 0, 1, 16'h0000, 8'h3C, el, ee, eq);
    do_req(1, 0, 1, 16'h0000, 8'h3C, lat, e, q);
    model(1, 1, 0, 16'h0000, 8'h00, el, ee, eq);
    do_req(1, 1, 0, 16'h0000, 8'h00, lat, e, q);
    model(1, 1, 0, 16'h0020, 8'h00, el, ee, eq);
    do_req(1, 1, 0, 16'h0020, 8'h00, lat, e, q);
    n_chk++; if (e !== ee) $display("FAIL oor_rd_err got %b want %b", e, ee); else n_pass++;
    n_chk++; if (q !== eq) $display("FAIL oor_rd_dout got %h want %h", q, eq); else n_pass++;
    model(1, 0, 1, 16'h0020, 8'h77, el, ee, eq);
    do_req(1, 0, 1, 16'h0020, 8'h77, lat, e, q);
    n_chk++; if (e !== ee) $display("FAIL oor_wr_err got %b want %b", e, ee); else n_pass++;
    model(1, 1, 0, 16'h0000, 8'h00, el, ee, eq);
    do_req(1, 1, 0, 16'h0000, 8'h00, lat, e, q);
    n_chk++; if (q !== eq) $display("FAIL oor_wr_dropped got %h want %h", q, eq); else n_pass++;
  endtask

  task automatic test_dump();
    int el, lat, first_v, last_v, done_c, ack_c, done_n, mism;
    logic ee, e; logic [7:0] eq, q;
    logic [7:0] words[$];
    bit early_ack, busy_done;
    for (int k = 0; k < 16; k++) begin
      model(1, 0, 1, 16'(k), 8'(k), el, ee, eq);
      do_req(1, 0, 1, 16'(k), 8'(k), lat, e, q);
    end
    model(1, 1, 0, 16'h0007, 8'h00, el, ee, eq);
    den[1] = 1'b1; rd[1] = 1'b1; addr[1] = 16'h0007;
    first_v = -1; last_v = -1; done_c = -1; ack_c = -1; done_n = 0;
    early_ack = 1'b0; busy_done = 1'b1; q = 8'h00; e = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (dvld[1]) begin
        words.push_back(ddat[1]);
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (ddone[1]) begin
        done_n++;
        if (done_c < 0) begin done_c = c; busy_done = busy[1]; den[1] = 1'b0; end
      end
      if (ack[1]) begin
        if (done_c < 0) early_ack = 1'b1;
        else if (ack_c < 0) begin ack_c = c; q = dout[1]; e = err[1]; rd[1] = 1'b0; end
      end
      if (ack_c > 0 && c > ack_c + 4) break;
    end
    den[1] = 1'b0; rd[1] = 1'b0;
    mism = 0;
    foreach (words[k]) if (k < 16 && words[k] !== small_mem[k]) mism++;
    n_chk++; if (words.size() !== 16) $display("FAIL dump_count got %0d want 16", words.size()); else n_pass++;
    n_chk++; if (mism !== 0) $display("FAIL dump_data got %0d wrong words want 0", mism); else n_pass++;
    n_chk++; if (last_v - first_v !== 15) $display("FAIL dump_contig got %0d want 15", last_v - first_v); else n_pass++;
    n_chk++; if (done_c !== last_v + 1) $display("FAIL dump_done_pos got %0d want %0d", done_c, last_v + 1); else n_pass++;
    n_chk++; if (done_n !== 1) $display("FAIL dump_done_pulses got %0d want 1", done_n); else n_pass++;
    n_chk++; if (busy_done !== 1'b0) $display("FAIL dump_busy_at_done got %b want 0", busy_done); else n_pass++;
    n_chk++; if (early_ack !== 1'b0) $display("FAIL dump_early_ack got %b want 0", early_ack); else n_pass++;
    n_chk++;
    if (ack_c < 0 || ack_c - done_c !== RD_LAT + 2) $display("FAIL dump_rd_after got %0d want %0d", ack_c - done_c, RD_LAT + 2);
    else n_pass++;
    n_chk++; if (q !== eq || e !== 1'b0) $display("FAIL dump_rd_data got %h/%b want %h/0", q, e, eq); else n_pass++;
  endtask

  task automatic test_random();
    int el, lat, sel, mism, done_c;
    logic ee, e, r, w; logic [7:0] eq, q, d; logic [15:0] a;
    logic [7:0] words[$];
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      a = 16'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      r = (sel <= 3); w = (sel >= 4 && sel <= 7);
      if (sel == 8) begin r = 1'b1; w = 1'b1; end
      if (sel == 9) begin
        a = 16'($urandom_range(16, 65535));
        w = 1'($urandom_range(0, 1)); r = !w;
      end
      model(1, r, w, a, d, el, ee, eq);
      do_req(1, r, w, a, d, lat, e, q);
      if (el >= 0) begin
        n_chk++; if (lat !== el) $display("FAIL rand_lat[%0d] got %0d want %0d", n, lat, el); else n_pass++;
      end
      n_chk++; if (e !== ee) $display("FAIL rand_err[%0d] got %b want %b", n, e, ee); else n_pass++;
      n_chk++; if (q !== eq) $display("FAIL rand_dout[%0d] got %h want %h", n, q, eq); else n_pass++;
    end
    den[1] = 1'b1; done_c = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (dvld[1]) words.push_back(ddat[1]);
      if (ddone[1]) begin done_c = c; den[1] = 1'b0; break; end
    end
    den[1] = 1'b0;
    @(posedge clk); #1;
    mism = 0;
    foreach (words[k]) if (k < 16 && words[k] !== small_mem[k]) mism++;
    n_chk++;
    if (done_c < 0 || words.size() !== 16 || mism !== 0)
      $display("FAIL rand_dump got %0d words %0d wrong want 16 words 0 wrong", words.size(), mism);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int el, lat, acks; logic ee, e; logic [7:0] eq, q;
    model(1, 0, 1, 16'h0003, 8'hC3, el, ee, eq);
    do_req(1, 0, 1, 16'h0003, 8'hC3, lat, e, q);
    model(1, 1, 0, 16'h0003, 8'h00, el, ee, eq);
    do_req(1, 1, 0, 16'h0003, 8'h00, lat, e, q);
    rd[1] = 1'b1; addr[1] = 16'h0003;
    @(posedge clk); #1;
    n_chk++; if (busy[1] !== 1'b1) $display("FAIL mid_busy got %b want 1", busy[1]); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ack, err, busy, dvld, ddone} !== 10'b0) $display("FAIL mid_reset_ctrl got %b want 0", {ack, err, busy, dvld, ddone});
    else n_pass++;
    n_chk++; if ({dout, ddat} !== 32'b0) $display("FAIL mid_reset_data got %h want 0", {dout, ddat}); else n_pass++;
    mdl_dout[0] = 8'h00; mdl_dout[1] = 8'h00;
    rd[1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ack[1] || ack[0]) acks++;
    end
    n_chk++; if (acks !== 0) $display("FAIL mid_no_ack got %0d acks want 0", acks); else n_pass++;
    model(1, 1, 0, 16'h0003, 8'h00, el, ee, eq);
    do_req(1, 1, 0, 16'h0003, 8'h00, lat, e, q);
    n_chk++; if (q !== eq) $display("FAIL mid_keep_small got %h want %h", q, eq); else n_pass++;
    model(0, 1, 0, 16'h0010, 8'h00, el, ee, eq);
    do_req(0, 1, 0, 16'h0010, 8'h00, lat, e, q);
    n_chk++; if (q !== eq) $display("FAIL mid_keep_big got %h want %h", q, eq); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_conflict();
    test_out_of_range();
    test_dump();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
